// File: rtl/ibex_multdiv_iter_pkg.sv
// Shared types and op-decode helpers for the iterative multiplier/divider
// and its result cache.
package ibex_multdiv_iter_pkg;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'd0,
        MD_OP_MULH   = 3'd1,
        MD_OP_MULHSU = 3'd2,
        MD_OP_MULHU  = 3'd3,
        MD_OP_DIV    = 3'd4,
        MD_OP_DIVU   = 3'd5,
        MD_OP_REM    = 3'd6,
        MD_OP_REMU   = 3'd7
    } md_iter_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_COMP,
        MD_SIGN,
        MD_DONE
    } md_iter_fsm_e;

    function automatic logic md_is_div(md_iter_op_e op);
        return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
    endfunction

    function automatic logic md_a_signed(md_iter_op_e op);
        return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
    endfunction

    function automatic logic md_b_signed(md_iter_op_e op);
        return op inside {MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
    endfunction

    // A divide entry holds quotient and remainder, so either half of a
    // same-signedness pair can be served; any full product serves MUL.
    function automatic logic md_cache_pair(md_iter_op_e entry_op, md_iter_op_e req_op);
        if (entry_op == req_op) begin
            return 1'b1;
        end
        if (md_is_div(entry_op) && md_is_div(req_op)) begin
            return md_a_signed(entry_op) == md_a_signed(req_op);
        end
        return !md_is_div(entry_op) && (req_op == MD_OP_MUL);
    endfunction

endpackage

// File: rtl/ibex_multdiv_result_cache.sv
// One-entry result cache holding the last full product or quotient/remainder
// pair, with hit compare and flush handling.
module ibex_multdiv_result_cache
    import ibex_multdiv_iter_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [2:0]         lookup_op_i,
    input  logic [Width-1:0]   lookup_a_i,
    input  logic [Width-1:0]   lookup_b_i,
    input  logic               lookup_dit_i,
    output logic               hit_o,
    output logic [2*Width-1:0] hit_data_o,
    input  logic               update_i,
    input  logic [2:0]         update_op_i,
    input  logic [Width-1:0]   update_a_i,
    input  logic [Width-1:0]   update_b_i,
    input  logic [2*Width-1:0] update_data_i
);

    logic               valid_q;
    md_iter_op_e        entry_op_q;
    logic [Width-1:0]   entry_a_q;
    logic [Width-1:0]   entry_b_q;
    logic [2*Width-1:0] entry_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            entry_op_q   <= MD_OP_MUL;
            entry_a_q    <= '0;
            entry_b_q    <= '0;
            entry_data_q <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (update_i) begin
                valid_q <= 1'b1;
            end
            if (update_i && !flush_i) begin
                entry_op_q   <= md_iter_op_e'(update_op_i);
                entry_a_q    <= update_a_i;
                entry_b_q    <= update_b_i;
                entry_data_q <= update_data_i;
            end
        end
    end

    assign hit_o = valid_q && !lookup_dit_i &&
                   (lookup_a_i == entry_a_q) && (lookup_b_i == entry_b_q) &&
                   md_cache_pair(entry_op_q, md_iter_op_e'(lookup_op_i));
    assign hit_data_o = entry_data_q;

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Radix-2 iterative multiplier/divider for the RV M extension, with an
// optional one-entry result cache for fused DIV/REM and MULH/MUL pairs.
module ibex_multdiv_iter
    import ibex_multdiv_iter_pkg::*;
#(
    parameter int unsigned Width       = 32,
    parameter bit          EnableCache = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [Width-1:0] req_a_i,
    input  logic [Width-1:0] req_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [Width-1:0] resp_result_o,
    output logic             resp_cache_hit_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(Width);

    md_iter_fsm_e       state_q;
    md_iter_op_e        op_q;
    logic               dit_q;
    logic               sign_a_q, sign_b_q;
    logic [Width-1:0]   a_q, b_q, a_abs_q, b_abs_q;
    logic [Width-1:0]   sh_q;
    logic [Width-1:0]   rem_q;
    logic [2*Width-1:0] acc_q, mcand_q;
    logic [CntW-1:0]    cnt_q;
    logic [Width-1:0]   result_q;
    logic               hit_q, ready_q, valid_q, busy_q;

    md_iter_op_e        req_op;
    logic               accept, req_sign_a, req_sign_b, div_by_zero;
    logic [Width-1:0]   req_a_abs, req_b_abs;
    logic               cache_hit, cache_update;
    logic [2*Width-1:0] cache_data;

    logic [Width:0]     div_partial, div_trial;
    logic               div_ge;
    logic [2*Width-1:0] mul_acc_nxt;
    logic [Width-1:0]   mul_sh_nxt;
    logic               comp_last;

    logic [2*Width-1:0] prod_signed, fused_signed;
    logic [Width-1:0]   quot_signed, rem_signed;

    function automatic logic [Width-1:0] md_select(md_iter_op_e op, logic [2*Width-1:0] fused);
        if (op inside {MD_OP_MUL, MD_OP_REM, MD_OP_REMU}) begin
            return fused[Width-1:0];
        end
        return fused[2*Width-1:Width];
    endfunction

    assign req_op      = md_iter_op_e'(req_op_i);
    assign accept      = req_valid_i && ready_q && !kill_i;
    assign req_sign_a  = md_a_signed(req_op) && req_a_i[Width-1];
    assign req_sign_b  = md_b_signed(req_op) && req_b_i[Width-1];
    assign req_a_abs   = req_sign_a ? '0 - req_a_i : req_a_i;
    assign req_b_abs   = req_sign_b ? '0 - req_b_i : req_b_i;
    assign div_by_zero = md_is_div(req_op) && (req_b_i == '0) && !data_ind_timing_i;

    // The partial remainder stays below the divisor, so bit Width of the
    // trial difference is a clean borrow flag.
    assign div_partial = {rem_q, sh_q[Width-1]};
    assign div_trial   = div_partial - {1'b0, b_abs_q};
    assign div_ge      = !div_trial[Width];

    assign mul_acc_nxt = sh_q[0] ? acc_q + mcand_q : acc_q;
    assign mul_sh_nxt  = sh_q >> 1;
    assign comp_last   = (cnt_q == '0) ||
                         (!md_is_div(op_q) && !dit_q && (mul_sh_nxt == '0));

    always_comb begin
        prod_signed = acc_q;
        quot_signed = sh_q;
        rem_signed  = rem_q;
        if (sign_a_q ^ sign_b_q) begin
            prod_signed = '0 - acc_q;
        end
        if ((sign_a_q ^ sign_b_q) && (b_q != '0)) begin
            quot_signed = '0 - sh_q;
        end
        if (sign_a_q) begin
            rem_signed = '0 - rem_q;
        end
        fused_signed = md_is_div(op_q) ? {quot_signed, rem_signed} : prod_signed;
    end

    assign cache_update = (state_q == MD_SIGN) && !kill_i;

    if (EnableCache) begin : g_cache
        ibex_multdiv_result_cache #(
            .Width(Width)
        ) u_cache (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .flush_i      (flush_i),
            .lookup_op_i  (req_op_i),
            .lookup_a_i   (req_a_i),
            .lookup_b_i   (req_b_i),
            .lookup_dit_i (data_ind_timing_i),
            .hit_o        (cache_hit),
            .hit_data_o   (cache_data),
            .update_i     (cache_update),
            .update_op_i  (op_q),
            .update_a_i   (a_q),
            .update_b_i   (b_q),
            .update_data_i(fused_signed)
        );
    end else begin : g_no_cache
        assign cache_hit  = 1'b0;
        assign cache_data = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_OP_MUL;
            dit_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            a_abs_q  <= '0;
            b_abs_q  <= '0;
            sh_q     <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hit_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (kill_i) begin
            state_q <= MD_IDLE;
            hit_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        op_q     <= req_op;
                        dit_q    <= data_ind_timing_i;
                        sign_a_q <= req_sign_a;
                        sign_b_q <= req_sign_b;
                        a_q      <= req_a_i;
                        b_q      <= req_b_i;
                        a_abs_q  <= req_a_abs;
                        b_abs_q  <= req_b_abs;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (cache_hit) begin
                            result_q <= md_select(req_op, cache_data);
                            hit_q    <= 1'b1;
                            valid_q  <= 1'b1;
                            state_q  <= MD_DONE;
                        end else if (div_by_zero) begin
                            result_q <= (req_op inside {MD_OP_REM, MD_OP_REMU}) ? req_a_i : '1;
                            hit_q    <= 1'b0;
                            valid_q  <= 1'b1;
                            state_q  <= MD_DONE;
                        end else begin
                            // sh_q carries the multiplier, or the dividend
                            // that is shifted out while quotient bits shift in.
                            acc_q   <= '0;
                            mcand_q <= {{Width{1'b0}}, req_a_abs};
                            sh_q    <= md_is_div(req_op) ? req_a_abs : req_b_abs;
                            rem_q   <= '0;
                            cnt_q   <= CntW'(Width - 1);
                            state_q <= MD_COMP;
                        end
                    end
                end
                MD_COMP: begin
                    if (md_is_div(op_q)) begin
                        rem_q <= div_ge ? div_trial[Width-1:0] : div_partial[Width-1:0];
                        sh_q  <= {sh_q[Width-2:0], div_ge};
                    end else begin
                        acc_q   <= mul_acc_nxt;
                        mcand_q <= mcand_q << 1;
                        sh_q    <= mul_sh_nxt;
                    end
                    if (comp_last) begin
                        state_q <= MD_SIGN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MD_SIGN: begin
                    result_q <= md_select(op_q, fused_signed);
                    hit_q    <= 1'b0;
                    valid_q  <= 1'b1;
                    state_q  <= MD_DONE;
                end
                MD_DONE: begin
                    if (resp_ready_i) begin
                        hit_q   <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= MD_IDLE;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign req_ready_o      = ready_q;
    assign resp_valid_o     = valid_q;
    assign resp_result_o    = result_q;
    assign resp_cache_hit_o = hit_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Table-driven bench for ibex_multdiv_iter with a result scoreboard and
// hand-written kill, flush and reset sequences.
module tb_ibex_multdiv_iter;
    import ibex_multdiv_iter_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         dit, kill, flush;
    logic         resp_valid, resp_ready, resp_hit, busy;
    logic [W-1:0] resp_result;

    ibex_multdiv_iter #(
        .Width(W),
        .EnableCache(1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_a_i          (req_a),
        .req_b_i          (req_b),
        .data_ind_timing_i(dit),
        .kill_i           (kill),
        .flush_i          (flush),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_result_o    (resp_result),
        .resp_cache_hit_o (resp_hit),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        md_iter_op_e  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         dit;
        logic [W-1:0] res;
        logic         hit;
        int           lat;
        int           hold;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         hit;
        int           lat;
        int           hold;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},  W'(req_ready),  W'(1));
        check({tag, "_valid"},  W'(resp_valid), W'(0));
        check({tag, "_busy"},   W'(busy),       W'(0));
        check({tag, "_result"}, resp_result,    W'(0));
        check({tag, "_hit"},    W'(resp_hit),   W'(0));
    endtask

    // Returns just after the accept edge, i.e. early in cycle 1.
    task automatic start_req(input md_iter_op_e op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic d, input string tag);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_req_ready"}, W'(req_ready), W'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        dit       = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        int   lat;
        start_req(v.op, v.a, v.b, v.dit, tag);
        sb.push_back('{v.res, v.hit, v.lat, v.hold});
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_resp_valid"}, W'(resp_valid), W'(1));
        check({tag, "_latency"},    W'(lat),        W'(e.lat));
        check({tag, "_result"},     resp_result,    e.res);
        check({tag, "_hit"},        W'(resp_hit),   W'(e.hit));
        check({tag, "_ready_in_done"}, W'(req_ready), W'(0));
        for (int i = 0; i < e.hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"},  W'(resp_valid), W'(1));
            check({tag, "_hold_result"}, resp_result,    e.res);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic seen;

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        dit = 1'b0; kill = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        //             op            a             b             dit   res           hit  lat hold
        vecs.push_back('{MD_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b0, 34, 5});
        vecs.push_back('{MD_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b0, 34, 0});
        vecs.push_back('{MD_OP_REM,    32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1,  0});
        vecs.push_back('{MD_OP_DIVU,   32'h00000007, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b0, 1,  0});
        vecs.push_back('{MD_OP_REM,    32'hFFFFFFF9, 32'h00000000, 1'b1, 32'hFFFFFFF9, 1'b0, 34, 0});
        vecs.push_back('{MD_OP_MUL,    32'h00000005, 32'h00000003, 1'b0, 32'h0000000F, 1'b0, 4,  0});
        vecs.push_back('{MD_OP_MULH,   32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFFF, 1'b0, 5,  0});
        vecs.push_back('{MD_OP_MUL,    32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFF1, 1'b1, 1,  3});
        vecs.push_back('{MD_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 34, 0});
        vecs.push_back('{MD_OP_DIV,    32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFD, 1'b0, 34, 0});
        vecs.push_back('{MD_OP_REM,    32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1,  0});
        vecs.push_back('{MD_OP_REMU,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h00000001, 1'b0, 34, 0});
        vecs.push_back('{MD_OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h7FFFFFFC, 1'b1, 1,  0});
        vecs.push_back('{MD_OP_MULHU,  32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 3,  0});
        vecs.push_back('{MD_OP_MUL,    32'h12345678, 32'h00000010, 1'b0, 32'h23456780, 1'b0, 7,  0});
        vecs.push_back('{MD_OP_MULH,   32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 1'b0, 7,  0});
        vecs.push_back('{MD_OP_DIV,    32'h00000064, 32'h00000007, 1'b0, 32'h0000000E, 1'b0, 34, 0});
        vecs.push_back('{MD_OP_REM,    32'h00000064, 32'h00000007, 1'b0, 32'h00000002, 1'b1, 1,  0});
        vecs.push_back('{MD_OP_REMU,   32'h00001234, 32'h00000000, 1'b0, 32'h00001234, 1'b0, 1,  0});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // Kill a divide in cycle 10; it must not respond or fill the cache.
        start_req(MD_OP_DIV, 32'h00000055, 32'h00000003, 1'b0, "kill");
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_ready", W'(req_ready),  W'(1));
        check("kill_valid", W'(resp_valid), W'(0));
        check("kill_busy",  W'(busy),       W'(0));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        check("kill_no_resp", W'(seen), W'(0));
        v = '{MD_OP_REM, 32'h00000055, 32'h00000003, 1'b0, 32'h00000001, 1'b0, 34, 0};
        run_op(v, "after_kill");

        // Flush drops the REM entry, so the paired DIV must recompute.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        v = '{MD_OP_DIV, 32'h00000055, 32'h00000003, 1'b0, 32'h0000001C, 1'b0, 34, 0};
        run_op(v, "after_flush");

        // Fill the cache, then reset in the middle of another divide.
        v = '{MD_OP_DIV, 32'h00000064, 32'h00000007, 1'b0, 32'h0000000E, 1'b0, 34, 0};
        run_op(v, "pre_reset");
        start_req(MD_OP_DIVU, 32'h00001000, 32'h00000003, 1'b1, "mid_reset");
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_idle_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        v = '{MD_OP_REM, 32'h00000064, 32'h00000007, 1'b0, 32'h00000002, 1'b0, 34, 0};
        run_op(v, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_multdiv_iter.md
Name: ibex_multdiv_iter

Overview:
- Self-contained, parametrised radix-2 iterative multiplier/divider. It is the successor to the slow multdiv and does not borrow the ALU adder.
- Executes all eight RV M-extension ops at configurable width behind valid/ready request and response handshakes.
- Adds an optional one-entry result cache that returns fused pairs in one cycle (DIV→REM, MULH→MUL), plus kill/flush support.
- Sits between the ID stage and the writeback mux; it replaces the ALU-shared multdiv when the ALU adder cannot be borrowed.

Parameters:
- Width, 32, operand/result width; must be ≥ 4.
- EnableCache, 1'b1, include the result cache; when 0, hit is tied low.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_op_i  in  3  md_iter_op_e
- req_a_i  in  Width  operand A
- req_b_i  in  Width  operand B
- data_ind_timing_i  in  1  sampled at accept; disables early exit and cache hit
- kill_i  in  1  abort the current operation
- flush_i  in  1  invalidate the cache
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_result_o  out  Width  result
- resp_cache_hit_o  out  1  result came from the cache
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, cache invalid. All outputs 0 except req_ready_o=1.
- Accept: req_valid_i && req_ready_o. The cycle in which accept occurs is "cycle 0".
- Accept registers the op, A, B and the dit flag. It also registers sign flags and |A|, |B| (negate when signed and MSB set).
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed only.
  - MUL, MULHU, DIVU, REMU: unsigned.
- FSM IDLE → COMP → SIGN → DONE → IDLE.
- IDLE to DONE directly (result visible cycle 1), in any of these cases:
  - Cache hit.
  - Divide by zero with dit=0. DIV/DIVU give all-ones; REM/REMU give A.
- COMP, multiply:
  - 2·Width accumulator plus a multiplicand that shifts left; multiplier shifts right.
  - Add when multiplier LSB is 1.
- COMP, divide:
  - Restoring division, MSB first, with a (Width+1)-bit trial subtract.
- COMP length: Width cycles (cycles 1..Width). Counter starts at Width-1 and exits at 0.
- Early exit (multiply only, dit=0): leave COMP once the shifted multiplier becomes 0.
- SIGN (one cycle):
  - Product negated (2·Width) when signA^signB.
  - Quotient negated when signA^signB and B≠0.
  - Remainder negated when signA.
  - Then select low/high half or quotient/remainder.
- Normal latency: resp_valid_o first high in cycle Width+2.
- DONE: resp_valid_o=1 and the result is held stable until resp_ready_i. Leaves to IDLE on resp_ready_i; no new accept in that same cycle.
- Cache update on entering DONE from SIGN:
  - Stores {family, signedness key, A, B, full product or quotient+remainder}.
  - The divider stores both quotient and remainder.
- Cache hit requires: valid, dit=0, A/B equal, and one of:
  - DIV/REM entry and new op is REM/DIV.
  - DIVU/REMU entry and new op is REMU/DIVU.
  - Any mult entry and new op is MUL.
  - Identical op.
- kill_i has priority in every state:
  - Next state is IDLE, no response, cache unchanged.
  - A kill during DONE drops the result.
- flush_i clears the cache valid bit. If it coincides with a cache update, flush wins.
- Overflow: DIV of 0x80..0 by all-ones gives 0x80..0; REM of the same gives 0. Both fall out of the unsigned-magnitude path with no special case.
- Asynchronous reset at any point (including mid-COMP): return to IDLE, drop the response, invalidate the cache.

Decomposition:
- ibex_pkg gets the following typedefs:
  - md_iter_op_e (3-bit, funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
  - md_iter_fsm_e (IDLE, COMP, SIGN, DONE).
- Sub-module ibex_multdiv_result_cache: holds the entry, the hit compare and the flush/update rules. It is instantiated only when EnableCache.

Test Plan (Width=32):
- MULHU 0xFFFFFFFF×0xFFFFFFFF, dit=1 → 0xFFFFFFFE; resp_valid_o first high exactly at cycle 34.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 34. Then REM with the same operands → 0x00000000, hit=1, cycle 1.
- DIVU 7/0, dit=0 → 0xFFFFFFFF at cycle 1. Then REM 0xFFFFFFF9/0, dit=1 → 0xFFFFFFF9 at cycle 34, hit=0.
- MUL 5×3, dit=0 → 0x0000000F at cycle 4 (early exit). MULH 0xFFFFFFFD×5 → 0xFFFFFFFF. Then MUL with the same operands → 0xFFFFFFF1, hit=1.
- kill_i in cycle 10 of a DIV → no resp_valid_o, req_ready_o=1 next cycle. A following REM with the same operands gives hit=0.
- Hold resp_ready_i low for 5 cycles in DONE → result stable. Separately, assert rst_i mid-COMP → IDLE, cache invalid, outputs at reset values.
